// File: rtl/mul_error_monitor_pkg.sv
// Shared types and width helpers for the multiplier error-metric monitors.
// The state encoding and derived widths live here so every monitor variant agrees on them.
package mul_metrics_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int pw_f(input int width);
        return 2 * width;
    endfunction

    // N samples of at most 2^PW-1 each fit in PW+SAMPLES_LOG2 bits
    function automatic int sum_w_f(input int width, input int slog2);
        return 2 * width + slog2;
    endfunction

    function automatic int cnt_w_f(input int slog2);
        return slog2 + 1;
    endfunction

endpackage

// File: rtl/mul_error_monitor_if.sv
// Sample input bus: operands plus the approximate product, with a valid/ready handshake.
interface mul_error_monitor_if #(
    parameter int WIDTH = 6
) ();
    localparam int PW = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [PW-1:0]    approx_prod;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output approx_prod,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  approx_prod,
        output in_ready
    );
endinterface

// File: rtl/mul_error_monitor_err_dist.sv
// Combinational error distance |a*b - approx| between the exact and the approximate product.
module mul_err_dist
    import mul_metrics_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0]       op_a,
    input  logic [WIDTH-1:0]       op_b,
    input  logic [pw_f(WIDTH)-1:0] approx_prod,
    output logic [pw_f(WIDTH)-1:0] ed
);
    localparam int PW = pw_f(WIDTH);

    logic [PW-1:0] w_exact;
    logic          w_exact_ge;

    assign w_exact    = op_a * op_b;
    // the comparison plays the role of the sign bit of a PW+1 bit difference
    assign w_exact_ge = (w_exact >= approx_prod);
    assign ed         = w_exact_ge ? (w_exact - approx_prod) : (approx_prod - w_exact);
endmodule

// File: rtl/mul_error_monitor.sv
// Accumulates error count, sum and maximum of the error distance over a run of 2^SAMPLES_LOG2 samples.
// Two-stage pipeline: S1 registers the error distance, S2 folds it into the running metrics.
module mul_error_monitor
    import mul_metrics_pkg::*;
#(
    parameter int WIDTH        = 6,
    parameter int SAMPLES_LOG2 = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    mul_error_monitor_if.slave                      smp,
    output logic                                    busy,
    output logic                                    done,
    output logic [cnt_w_f(SAMPLES_LOG2)-1:0]        err_count,
    output logic [sum_w_f(WIDTH, SAMPLES_LOG2)-1:0] err_sum,
    output logic [pw_f(WIDTH)-1:0]                  err_max
);
    localparam int PW = pw_f(WIDTH);
    localparam int SW = sum_w_f(WIDTH, SAMPLES_LOG2);
    localparam int CW = cnt_w_f(SAMPLES_LOG2);
    localparam int N  = 1 << SAMPLES_LOG2;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_sample_cnt;
    logic          r_s1_valid;
    logic [PW-1:0] r_s1_ed;
    logic [CW-1:0] r_err_count;
    logic [SW-1:0] r_err_sum;
    logic [PW-1:0] r_err_max;
    logic [PW-1:0] w_ed;
    logic          w_accept;
    logic          w_clear;
    logic          w_in_ready;
    logic          w_busy;
    logic          w_done;

    mul_err_dist #(.WIDTH(WIDTH)) u_err_dist (
        .op_a       (smp.op_a),
        .op_b       (smp.op_b),
        .approx_prod(smp.approx_prod),
        .ed         (w_ed)
    );

    assign w_accept = smp.in_valid && (r_state == RUN);

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_accept && (r_sample_cnt == LAST_IDX)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                // S2 commits in the same cycle S1 empties, so metrics are final one cycle later
                if (!r_s1_valid) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_ed      <= '0;
            r_err_count  <= '0;
            r_err_sum    <= '0;
            r_err_max    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ed <= w_ed;
            end
            if (w_clear) begin
                r_sample_cnt <= '0;
                r_err_count  <= '0;
                r_err_sum    <= '0;
                r_err_max    <= '0;
            end else begin
                if (w_accept) begin
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                end
                if (r_s1_valid) begin
                    r_err_sum   <= r_err_sum + SW'(r_s1_ed);
                    r_err_count <= r_err_count + CW'(r_s1_ed != '0);
                    if (r_s1_ed > r_err_max) begin
                        r_err_max <= r_s1_ed;
                    end
                end
            end
        end
    end

    assign smp.in_ready = w_in_ready;
    assign busy         = w_busy;
    assign done         = w_done;
    assign err_count    = r_err_count;
    assign err_sum      = r_err_sum;
    assign err_max      = r_err_max;
endmodule

// File: tb/tb_mul_error_monitor.sv
// Scoreboard bench: each run pushes its hand-computed metrics; a monitor pops them on every done pulse.
module tb_mul_error_monitor;
    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] p;
    } smp_t;

    typedef struct {
        logic [2:0]  cnt;
        logic [13:0] sum;
        logic [11:0] max;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  err_count;
    logic [13:0] err_sum;
    logic [11:0] err_max;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    mul_error_monitor_if #(.WIDTH(6)) sif ();

    mul_error_monitor #(.WIDTH(6), .SAMPLES_LOG2(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .smp      (sif),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .err_sum  (err_sum),
        .err_max  (err_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus tables: operand a, operand b, approximate product
    smp_t v_exact[4] = '{'{6'd3, 6'd5, 12'd15}, '{6'd7, 6'd9, 12'd63},
                         '{6'd0, 6'd63, 12'd0}, '{6'd63, 6'd63, 12'd3969}};
    smp_t v_mixed[4] = '{'{6'd3, 6'd5, 12'd18}, '{6'd7, 6'd9, 12'd58},
                         '{6'd2, 6'd2, 12'd4}, '{6'd10, 6'd10, 12'd100}};
    smp_t v_ext1[4]  = '{'{6'd63, 6'd63, 12'd0}, '{6'd63, 6'd63, 12'd0},
                         '{6'd63, 6'd63, 12'd0}, '{6'd63, 6'd63, 12'd0}};
    smp_t v_ext2[4]  = '{'{6'd0, 6'd0, 12'd4095}, '{6'd63, 6'd63, 12'd0},
                         '{6'd1, 6'd1, 12'd1}, '{6'd0, 6'd0, 12'd0}};
    smp_t v_hs[4]    = '{'{6'd1, 6'd2, 12'd2}, '{6'd3, 6'd3, 12'd10},
                         '{6'd5, 6'd5, 12'd25}, '{6'd6, 6'd7, 12'd40}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("err_count", 32'(err_count), 32'(e_mon.cnt));
                chk("err_sum", 32'(err_sum), 32'(e_mon.sum));
                chk("err_max", 32'(err_max), 32'(e_mon.max));
                $display("run result: count=%0d sum=%0d max=%0d", err_count, err_sum, err_max);
            end
        end
    end

    // all tasks start and end one time unit after a rising edge
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input smp_t s);
        int guard = 0;
        sif.in_valid    = 1'b1;
        sif.op_a        = s.a;
        sif.op_b        = s.b;
        sif.approx_prod = s.p;
        @(negedge clk);
        while (!sif.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk("send_ready", 32'(sif.in_ready), 32'd1);
        $display("sample a=%0d b=%0d approx=%0d", s.a, s.b, s.p);
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt != base), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input smp_t v[4], input exp_t e, input bit mid_start);
        int base = done_cnt;
        exp_q.push_back(e);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (mid_start && i == 2) pulse_start();
            send(v[i]);
        end
        wait_done(base);
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(sif.in_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cnt"}, 32'(err_count), 32'd0);
        chk({tag, "_sum"}, 32'(err_sum), 32'd0);
        chk({tag, "_max"}, 32'(err_max), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   acc;
        int   k;
        int   t_last;
        int   base;
        exp_t e_hold;

        sif.in_valid = 1'b0;
        sif.op_a = '0;
        sif.op_b = '0;
        sif.approx_prod = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_zero("reset");

        run_block(v_exact, '{3'd0, 14'd0, 12'd0}, 1'b0);
        run_block(v_mixed, '{3'd2, 14'd8, 12'd5}, 1'b0);
        run_block(v_ext1, '{3'd4, 14'd15876, 12'd3969}, 1'b0);
        run_block(v_ext2, '{3'd2, 14'd8064, 12'd4095}, 1'b0);

        // handshake and latency with gaps in in_valid
        base = done_cnt;
        acc = 0;
        k = 0;
        t_last = 0;
        exp_q.push_back('{3'd2, 14'd3, 12'd2});
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            sif.in_valid = pat[i];
            if (pat[i]) begin
                sif.op_a = v_hs[k].a;
                sif.op_b = v_hs[k].b;
                sif.approx_prod = v_hs[k].p;
            end
            @(negedge clk);
            if (sif.in_valid && sif.in_ready) begin
                acc++;
                t_last = cyc;
                k++;
            end
            @(posedge clk); #1;
        end
        chk("accepts_in_pattern", 32'(acc), 32'd4);
        sif.in_valid = 1'b1;
        sif.op_a = 6'd0;
        sif.op_b = 6'd0;
        sif.approx_prod = 12'd4095;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (j == 0) chk("ready_low_after_last", 32'(sif.in_ready), 32'd0);
            if (sif.in_ready) acc++;
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
        wait_done(base);
        chk("accepts_total", 32'(acc), 32'd4);
        chk("done_latency", 32'(done_cyc), 32'(t_last + 3));
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // start during RUN is ignored; results then hold until the next start
        e_hold = '{3'd2, 14'd8, 12'd5};
        run_block(v_mixed, e_hold, 1'b1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("hold_cnt", 32'(err_count), 32'(e_hold.cnt));
            chk("hold_sum", 32'(err_sum), 32'(e_hold.sum));
            chk("hold_max", 32'(err_max), 32'(e_hold.max));
            @(posedge clk); #1;
        end
        pulse_start();
        @(negedge clk);
        chk("clear_cnt", 32'(err_count), 32'd0);
        chk("clear_sum", 32'(err_sum), 32'd0);
        chk("clear_max", 32'(err_max), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;

        // reset after two accepts discards the partial run
        send(v_mixed[0]);
        send(v_mixed[1]);
        base = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("midrst");
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_cnt), 32'(base));

        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check_idle_zero("rst_and_start");

        run_block(v_mixed, '{3'd2, 14'd8, 12'd5}, 1'b0);
        chk("pending_runs", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
